// File: rtl/game_pkg.sv
// Shared definitions for the memory-game datapath: FSM states, letter glyphs,
// LFSR constants and the saturating BCD score adder.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAY_ON  = 3'd1,
    S_PLAY_OFF = 3'd2,
    S_INPUT    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // Active-low segments, bit order gfedcba (same as dec7seg)
  localparam logic [6:0] SEG_L = 7'b1000111;
  localparam logic [6:0] SEG_T = 7'b0000111;
  localparam logic [6:0] SEG_R = 7'b0101111;
  localparam logic [6:0] SEG_U = 7'b1000001;
  localparam logic [6:0] SEG_S = 7'b0010010;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [6:0] SEG_P = 7'b0001100;
  localparam logic [6:0] SEG_G = 7'b1000010;
  localparam logic [6:0] SEG_A = 7'b0001000;

  // Taps 8,6,5,4 -> state bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam logic [3:0] LFSR_SEED_HI = 4'hA;
  localparam logic [7:0] LFSR_RESET   = 8'hA1;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [7:0] bcd_sat_add(input logic [7:0] a, input logic [2:0] b);
    int unsigned s;
    s = 32'(a[7:4]) * 10 + 32'(a[3:0]) + 32'(b);
    if (s > 99) s = 99;
    return {4'(s / 10), 4'(s % 10)};
  endfunction

endpackage

// File: rtl/dec7seg.sv
// Hex digit to active-low 7-segment pattern (bit order gfedcba).
module dec7seg (
  input  logic [3:0] d,
  output logic [6:0] seg
);
  always_comb begin
    case (d)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end
endmodule

// File: rtl/seq_game_datapath_lfsr8.sv
// 8-bit Fibonacci LFSR; a load with advance steps from the loaded value.
module lfsr8
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       advance,
  output logic [7:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)       q <= LFSR_RESET;
    else if (load)    q <= advance ? lfsr_step(load_val) : load_val;
    else if (advance) q <= lfsr_step(q);
  end
endmodule

// File: rtl/seq_game_datapath.sv
// Memory-game datapath: pattern memory, LED playback, input comparison,
// countdown timer, BCD score, round counter and HEX view mux.
module seq_game_datapath
  import game_pkg::*;
#(
  parameter int unsigned N_KEY       = 4,
  parameter int unsigned N_ROUNDS    = 16,
  parameter int unsigned TIME_LIMIT  = 9,
  parameter int unsigned TICK_CYCLES = 50_000_000,
  parameter int unsigned STEP_CYCLES = 25_000_000
) (
  input  logic             CLOCK_50,
  input  logic             R,
  input  logic [N_KEY-1:0] KEY,
  input  logic [7:0]       SWITCH,
  input  logic             start,
  input  logic             next_round,
  input  logic             e_time,
  input  logic             show,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3,
  output logic [6:0]       hex4,
  output logic [6:0]       hex5,
  output logic [N_KEY-1:0] leds,
  output logic             end_FPGA,
  output logic             end_User,
  output logic             end_time,
  output logic             win,
  output logic             match
);
  localparam int unsigned KW  = $clog2(N_KEY);
  localparam int unsigned TW  = $clog2(TICK_CYCLES + 1);
  localparam int unsigned STW = $clog2(STEP_CYCLES + 1);

  state_t           state;
  logic [1:0]       level;
  logic [4:0]       round;
  logic [3:0]       step;
  logic [3:0]       idx;
  logic [7:0]       points;
  logic [3:0]       timer;
  logic [TW-1:0]    presc;
  logic [STW-1:0]   slot;
  logic [N_KEY-1:0] seq [16];

  logic [7:0]       lfsr_q;
  logic             do_next;
  logic [KW-1:0]    append_bits;
  logic [N_KEY-1:0] append_onehot;
  logic [3:0]       append_idx;
  logic             key_hit;
  logic             tick;
  logic             slot_end;
  logic [6:0]       dig0, dig_tens, dig_timer, dig_level;
  logic             unused_ok;

  assign do_next       = (state == S_DONE) && next_round && match && !win;
  // start appends from the freshly seeded value, so its index bits come from SWITCH
  assign append_bits   = start ? SWITCH[KW-1:0] : lfsr_q[KW-1:0];
  assign append_onehot = N_KEY'(1) << append_bits;
  assign append_idx    = start ? 4'd0 : round[3:0];
  assign key_hit       = $onehot(KEY) && (KEY == seq[idx]);
  assign tick          = (presc == TW'(TICK_CYCLES - 1));
  assign slot_end      = (slot == STW'(STEP_CYCLES - 1));
  assign unused_ok     = ^{SWITCH[5:4], lfsr_q[7:KW]};

  lfsr8 u_lfsr (
    .clk      (CLOCK_50),
    .rst_n    (R),
    .load     (start),
    .load_val ({LFSR_SEED_HI, SWITCH[3:0]}),
    .advance  (start || do_next),
    .q        (lfsr_q)
  );

  always_ff @(posedge CLOCK_50) begin
    if (R && (start || do_next)) seq[append_idx] <= append_onehot;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!R) begin
      state    <= S_IDLE;
      level    <= '0;
      round    <= '0;
      step     <= '0;
      idx      <= '0;
      points   <= '0;
      timer    <= 4'(TIME_LIMIT);
      presc    <= '0;
      slot     <= '0;
      leds     <= '0;
      end_FPGA <= 1'b0;
      end_User <= 1'b0;
      end_time <= 1'b0;
      win      <= 1'b0;
      match    <= 1'b0;
    end else begin
      end_FPGA <= 1'b0;
      end_User <= 1'b0;
      end_time <= 1'b0;
      if (start) begin
        level  <= SWITCH[7:6];
        round  <= 5'd1;
        points <= '0;
        win    <= 1'b0;
        match  <= 1'b0;
        step   <= '0;
        slot   <= '0;
        leds   <= append_onehot;
        state  <= S_PLAY_ON;
      end else begin
        case (state)
          S_PLAY_ON: begin
            if (slot_end) begin
              slot  <= '0;
              leds  <= '0;
              state <= S_PLAY_OFF;
            end else begin
              slot <= slot + STW'(1);
            end
          end
          S_PLAY_OFF: begin
            if (slot_end) begin
              slot <= '0;
              if (5'(step) != round - 5'd1) begin
                step  <= step + 4'd1;
                leds  <= seq[step + 4'd1];
                state <= S_PLAY_ON;
              end else begin
                end_FPGA <= 1'b1;
                timer    <= 4'(TIME_LIMIT);
                presc    <= '0;
                idx      <= '0;
                state    <= S_INPUT;
              end
            end else begin
              slot <= slot + STW'(1);
            end
          end
          S_INPUT: begin
            leds <= '0;
            if (e_time) presc <= tick ? '0 : presc + TW'(1);
            // Expiry takes precedence over a key landing in the same cycle
            if (e_time && tick && timer == 4'd1) begin
              timer    <= '0;
              end_time <= 1'b1;
              match    <= 1'b0;
              state    <= S_DONE;
            end else begin
              if (e_time && tick) timer <= timer - 4'd1;
              if (KEY != '0) begin
                leds <= KEY;
                if (!key_hit) begin
                  match    <= 1'b0;
                  end_User <= 1'b1;
                  state    <= S_DONE;
                end else if (5'(idx) == round - 5'd1) begin
                  match    <= 1'b1;
                  points   <= bcd_sat_add(points, 3'(level) + 3'd1);
                  end_User <= 1'b1;
                  if (round == 5'(N_ROUNDS)) win <= 1'b1;
                  state    <= S_DONE;
                end else begin
                  idx <= idx + 4'd1;
                end
              end
            end
          end
          S_DONE: begin
            leds <= '0;
            if (do_next) begin
              round <= round + 5'd1;
              step  <= '0;
              slot  <= '0;
              leds  <= seq[0];
              state <= S_PLAY_ON;
            end
          end
          default: leds <= '0;
        endcase
      end
    end
  end

  dec7seg u_dig0  (.d(show ? points[3:0] : round[3:0]), .seg(dig0));
  dec7seg u_tens  (.d(points[7:4]),                     .seg(dig_tens));
  dec7seg u_timer (.d(timer),                           .seg(dig_timer));
  dec7seg u_level (.d({2'b00, level}),                  .seg(dig_level));

  always_comb begin
    hex0 = dig0;
    hex1 = show ? dig_tens : SEG_R;
    hex2 = show ? (win ? SEG_R : SEG_A) : dig_timer;
    hex3 = show ? (win ? SEG_E : SEG_G) : SEG_T;
    hex4 = show ? (win ? SEG_S : SEG_P) : dig_level;
    hex5 = show ? (win ? SEG_U : SEG_F) : SEG_L;
  end

endmodule
